// File: rtl/operand_demux_pkg.sv
// Shared types and constants for the serial-to-parallel operand demultiplexer.
// Optional overflow flag is enabled by defining OPERAND_DEMUX_OVF_EN.
package operand_demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/operand_demux_if.sv
// Handshake/bus bundle for operand_demux; slave = the demux, master = producer/consumer.
// The ovf signal exists only when OPERAND_DEMUX_OVF_EN is defined.
interface operand_demux_if
    import operand_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             din;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic             out_ready;
`ifdef OPERAND_DEMUX_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  din, sel, in_valid, out_ready,
`ifdef OPERAND_DEMUX_OVF_EN
        output ovf,
`endif
        output in_ready, a_out, b_out, out_valid
    );

    modport master (
        output din, sel, in_valid, out_ready,
`ifdef OPERAND_DEMUX_OVF_EN
        input  ovf,
`endif
        input  in_ready, a_out, b_out, out_valid
    );

endinterface

// File: rtl/operand_demux_lane.sv
// One operand lane: LSB-first right-shift register with a saturating fill counter.
// Bits offered while the lane is full are dropped here without touching state.
module demux_lane
    import operand_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             full_next_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             full;

    assign full = (cnt_q == CW'(WIDTH));

    // Full after this edge: already full, or the final bit is being shifted in now.
    assign full_next_o = full || (shift_en_i && (cnt_q == CW'(WIDTH - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
        end else if (shift_en_i && !full) begin
            data_q <= {bit_i, data_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign data_o = data_q;
    assign full_o = full;

endmodule

// File: rtl/operand_demux.sv
// Serial operand demultiplexer: sel steers each accepted din bit into lane A or B.
// Define OPERAND_DEMUX_OVF_EN to add the sticky ovf flag for discarded bits.
module operand_demux
    import operand_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_demux_if.slave        bus
);

    state_e state_q;
    logic   in_ready_q;
    logic   out_valid_q;

    logic             accept;
    logic             shift_a;
    logic             shift_b;
    logic             clr;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic             a_full;
    logic             b_full;
    logic             a_full_next;
    logic             b_full_next;

    assign accept  = bus.in_valid && in_ready_q;
    assign shift_a = accept && !bus.sel;
    assign shift_b = accept &&  bus.sel;
    assign clr     = out_valid_q && bus.out_ready;

    demux_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk         (clk),
        .rst         (rst),
        .shift_en_i  (shift_a),
        .clr_i       (clr),
        .bit_i       (bus.din),
        .data_o      (a_data),
        .full_o      (a_full),
        .full_next_o (a_full_next)
    );

    demux_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk         (clk),
        .rst         (rst),
        .shift_en_i  (shift_b),
        .clr_i       (clr),
        .bit_i       (bus.din),
        .data_o      (b_data),
        .full_o      (b_full),
        .full_next_o (b_full_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (a_full_next && b_full_next) begin
                        state_q     <= HOLD;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPERAND_DEMUX_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((shift_a && a_full) || (shift_b && b_full)) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.a_out     = a_data;
    assign bus.b_out     = b_data;

endmodule

// File: tb/tb_operand_demux.sv
// Self-checking bench for operand_demux (WIDTH=8) against a queue-based reference model.
// Build with OPERAND_DEMUX_OVF_EN defined to also check the ovf flag.
module tb_operand_demux;
    import operand_demux_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operand_demux_if #(.WIDTH(W)) bus ();

    operand_demux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: each lane is the list of bits it has collected this round.
    bit           qa[$];
    bit           qb[$];
    bit           m_hold;
    bit           m_ovf;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    function automatic logic [W-1:0] pack(input bit q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v[i] = q[i];
        return v;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_hold = 1'b0;
        m_ovf  = 1'b0;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic drive_cycle(input bit v, input bit s, input bit d, input bit r);
        bus.in_valid  = v;
        bus.sel       = s;
        bus.din       = d;
        bus.out_ready = r;
        if (!m_hold) begin
            if (v) begin
                if (s) begin
                    if (qb.size() < W) qb.push_back(d); else m_ovf = 1'b1;
                end else begin
                    if (qa.size() < W) qa.push_back(d); else m_ovf = 1'b1;
                end
            end
            if (qa.size() == W && qb.size() == W) begin
                m_hold = 1'b1;
                m_a    = pack(qa);
                m_b    = pack(qb);
            end
        end else if (r) begin
            m_hold = 1'b0;
            qa.delete();
            qb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sel       = 1'b0;
        bus.din       = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
        tests++;
        if (bus.a_out !== '0 || bus.b_out !== '0) begin
            fails++;
            $display("FAIL reset_data: a=%h b=%h, want 00/00", bus.a_out, bus.b_out);
        end
`ifdef OPERAND_DEMUX_OVF_EN
        tests++;
        if (bus.ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: ovf=%b, want 0", bus.ovf);
        end
`endif
    endtask

    task automatic test_alternating();
        logic [7:0] av = 8'hA5;
        logic [7:0] bv = 8'h3C;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, i[0], i[0] ? bv[i/2] : av[i/2], 1'b1);
            tests++;
            if (bus.out_valid !== m_hold || bus.in_ready !== ~m_hold) begin
                fails++;
                $display("FAIL alt_hs bit%0d: out_valid=%b in_ready=%b, want %b/%b", i, bus.out_valid, bus.in_ready, m_hold, ~m_hold);
            end
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'hA5 || bus.b_out !== 8'h3C) begin
            fails++;
            $display("FAIL alt_data: v=%b a=%h b=%h, want 1 a5 3c", bus.out_valid, bus.a_out, bus.b_out);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL alt_one_hold: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_hold_stall();
        logic [7:0] bv = 8'h01;
        apply_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, bv[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.a_out !== 8'hFF || bus.b_out !== 8'h01) begin
                fails++;
                $display("FAIL stall_hold cyc%0d: v=%b rdy=%b a=%h b=%h, want 1 0 ff 01", i, bus.out_valid, bus.in_ready, bus.a_out, bus.b_out);
            end
            drive_cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] av = 8'h5B;
        logic [7:0] bv = 8'hC6;
        apply_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, av[i], 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_nodone: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
`ifdef OPERAND_DEMUX_OVF_EN
        tests++;
        if (bus.ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag: ovf=%b, want 1", bus.ovf);
        end
`endif
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, bv[i], 1'b0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'h5B || bus.b_out !== 8'hC6) begin
            fails++;
            $display("FAIL ovf_data: v=%b a=%h b=%h, want 1 5b c6", bus.out_valid, bus.a_out, bus.b_out);
        end
`ifdef OPERAND_DEMUX_OVF_EN
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (bus.ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: ovf=%b, want 1", bus.ovf);
        end
`endif
    endtask

    task automatic test_gapped_valid();
        logic [7:0] av = 8'hA5;
        logic [7:0] bv = 8'h3C;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            int k = i / 2;
            drive_cycle(~i[0], k[0], k[0] ? bv[k/2] : av[k/2], 1'b0);
            tests++;
            if (bus.out_valid !== m_hold || bus.in_ready !== ~m_hold) begin
                fails++;
                $display("FAIL gap_hs cyc%0d: out_valid=%b in_ready=%b, want %b/%b", i, bus.out_valid, bus.in_ready, m_hold, ~m_hold);
            end
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== 8'hA5 || bus.b_out !== 8'h3C) begin
            fails++;
            $display("FAIL gap_data: v=%b a=%h b=%h, want 1 a5 3c", bus.out_valid, bus.a_out, bus.b_out);
        end
    endtask

    task automatic test_reset_midfill();
        apply_reset();
        for (int i = 0; i < 11; i++) drive_cycle(1'b1, i[0], 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.a_out !== '0 || bus.b_out !== '0) begin
            fails++;
            $display("FAIL midrst_async: v=%b a=%h b=%h, want 0 00 00", bus.out_valid, bus.a_out, bus.b_out);
        end
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_quiet cyc%0d: out_valid=%b, want 0", i, bus.out_valid);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, i[0], 1'($urandom), 1'b0);
            tests++;
            if (bus.out_valid !== m_hold || bus.in_ready !== ~m_hold) begin
                fails++;
                $display("FAIL midrst_hs bit%0d: out_valid=%b in_ready=%b, want %b/%b", i, bus.out_valid, bus.in_ready, m_hold, ~m_hold);
            end
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.a_out !== m_a || bus.b_out !== m_b) begin
            fails++;
            $display("FAIL midrst_data: v=%b a=%h b=%h, want 1 %h %h", bus.out_valid, bus.a_out, bus.b_out, m_a, m_b);
        end
    endtask

    task automatic test_back_to_back();
        int holds = 0;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            logic [7:0] av = 8'($urandom);
            logic [7:0] bv = 8'($urandom);
            bit sels[16];
            int idx = 0, ai = 0, bi = 0, guard = 0;
            for (int i = 0; i < 16; i++) sels[i] = (i >= 8);
            for (int i = 15; i > 0; i--) begin
                int j = $urandom_range(i, 0);
                bit t = sels[i];
                sels[i] = sels[j];
                sels[j] = t;
            end
            while (idx < 16 && guard < 64) begin
                bit s = sels[idx];
                bit acc = bus.in_ready;
                drive_cycle(1'b1, s, s ? bv[bi] : av[ai], 1'b1);
                guard++;
                if (acc) begin
                    idx++;
                    if (s) bi++; else ai++;
                end
                if (bus.out_valid === 1'b1) holds++;
            end
            tests++;
            if (idx < 16 || bus.out_valid !== 1'b1 || bus.a_out !== av || bus.b_out !== bv) begin
                fails++;
                $display("FAIL b2b_pair%0d: bits=%0d v=%b a=%h b=%h, want 16 1 %h %h", p, idx, bus.out_valid, bus.a_out, bus.b_out, av, bv);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        if (bus.out_valid === 1'b1) holds++;
        tests++;
        if (holds != 4) begin
            fails++;
            $display("FAIL b2b_holds: hold cycles=%0d, want 4", holds);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
            tests++;
            if (bus.out_valid !== m_hold || bus.in_ready !== ~m_hold) begin
                fails++;
                $display("FAIL rand_hs cyc%0d: out_valid=%b in_ready=%b, want %b/%b", i, bus.out_valid, bus.in_ready, m_hold, ~m_hold);
            end
            if (m_hold) begin
                tests++;
                if (bus.a_out !== m_a || bus.b_out !== m_b) begin
                    fails++;
                    $display("FAIL rand_data cyc%0d: a=%h b=%h, want %h %h", i, bus.a_out, bus.b_out, m_a, m_b);
                end
            end
`ifdef OPERAND_DEMUX_OVF_EN
            tests++;
            if (bus.ovf !== m_ovf) begin
                fails++;
                $display("FAIL rand_ovf cyc%0d: ovf=%b, want %b", i, bus.ovf, m_ovf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_hold_stall();
        test_overflow();
        test_gapped_valid();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_demux.md
OPERAND_DEMUX -- requirements
Module: operand_demux

Interface
REQ-001 Parameter WIDTH, default 8; bits per operand lane; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 din  input  1  serial operand bit.
REQ-005 sel  input  1  lane select for din; 1 routes to lane I1 (b_out), 0 routes to lane I0 (a_out).
REQ-006 in_valid  input  1  din/sel valid this cycle.
REQ-007 in_ready  output  1  block accepts din this cycle.
REQ-008 a_out  output  WIDTH  assembled lane-I0 operand.
REQ-009 b_out  output  WIDTH  assembled lane-I1 operand.
REQ-010 out_valid  output  1  a_out/b_out complete and stable.
REQ-011 out_ready  input  1  consumer takes the operand pair.
REQ-012 ovf  output  1  sticky overflow flag; present only under OPERAND_DEMUX_OVF_EN.

Function
REQ-013 Block SHALL be the inverse of the 2:1 operand select: one serial stream, demultiplexed by sel into two WIDTH-bit shift lanes.
REQ-014 Transfer on a cycle with in_valid && in_ready; no other cycle SHALL alter a lane.
REQ-015 Lanes fill LSB first: each accepted bit shifts the selected lane right, entering at bit WIDTH-1; after WIDTH bits, the first bit sits at bit 0.
REQ-016 Each lane SHALL have a fill counter of width $clog2(WIDTH+1), saturating at WIDTH.
REQ-017 A bit routed to a lane whose counter equals WIDTH SHALL be accepted and discarded; lane contents and counter unchanged.
REQ-018 FSM states: FILL, HOLD.
REQ-019 FILL: in_ready=1, out_valid=0; move to HOLD on the clock edge where both counters reach WIDTH.
REQ-020 HOLD: in_ready=0, out_valid=1; a_out/b_out frozen.
REQ-021 HOLD->FILL on out_valid && out_ready; both counters cleared that edge; a_out/b_out retain their values until overwritten by shifting.
REQ-022 Latency: out_valid SHALL rise the cycle after the transfer completing the second lane.
REQ-023 A handshake with out_ready high in the first HOLD cycle SHALL return to FILL after exactly one HOLD cycle.
REQ-024 in_ready is registered state only; it SHALL NOT depend combinationally on in_valid, sel, or out_ready.
REQ-025 out_ready in FILL SHALL be ignored.

Reset
REQ-026 On rst: state=FILL, counters=0, a_out=0, b_out=0, out_valid=0, in_ready=1 after release, ovf=0.
REQ-027 rst asserted mid-fill or in HOLD SHALL abandon partial or pending operands with no out_valid pulse.

Configuration
REQ-028 Macro OPERAND_DEMUX_OVF_EN defined: ovf port present; set on any discarded bit (REQ-017); cleared only by rst.
REQ-029 Macro undefined: no ovf port or register; discarded bits silently dropped; all other behaviour identical.

Structure
REQ-030 Package operand_demux_pkg SHALL hold the FSM state enum (FILL, HOLD) and constant DEFAULT_WIDTH = 8.
REQ-031 Sub-module demux_lane (WIDTH-bit shift register, fill counter, full flag, shift-enable and clear inputs) SHALL be instantiated twice, one per lane.

Verification (WIDTH=8)
REQ-032 Alternating sel 0,1 for 16 bits, A=0xA5 and B=0x3C LSB first, out_ready=1 -> out_valid one cycle after bit 16, a_out=0xA5, b_out=0x3C, one HOLD cycle.
REQ-033 Eight sel=0 bits (0xFF), then eight sel=1 bits (0x01) with out_ready=0 for 5 cycles -> out_valid held 5+ cycles, in_ready=0, outputs stable; then out_ready=1 -> FILL next edge.
REQ-034 Nine sel=0 bits (last bit 0) then eight sel=1 bits -> a_out equals first eight bits, 9th discarded; ovf=1 with macro, port absent without.
REQ-035 in_valid toggled 1/0 each cycle during fill -> only valid cycles counted; result same as REQ-032.
REQ-036 rst pulsed after 11 accepted bits -> counters zero, outputs 0, out_valid never asserted; fresh 16-bit sequence then completes correctly.
REQ-037 Back-to-back pairs, out_ready tied 1 -> each pair is correct, with exactly one HOLD cycle between pairs and no bit lost.
